// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser
//  Description : Frame decoder fed by the UART receiver byte strobe. Assembles
//                HEAD0 HEAD1 ADDR DATH DATL CHK frames, verifies the 8-bit
//                wrapping checksum and issues a one-cycle register write for
//                good frames. Reports checksum errors and inter-byte timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter logic [7:0]  HEAD0       = 8'h55,
    parameter logic [7:0]  HEAD1       = 8'hAA,
    parameter logic [19:0] TIMEOUT_END = 20'd520833
) (
    input  logic        s_clk,
    input  logic        s_rst_n,
    input  logic [7:0]  data_rx,
    input  logic        po_flag,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        chk_err,
    output logic        to_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S_HEAD1 = 3'd1,
        S_ADDR  = 3'd2,
        S_DATH  = 3'd3,
        S_DATL  = 3'd4,
        S_CHK   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  addr_sh_q, addr_sh_d;
    logic [7:0]  dath_sh_q, dath_sh_d;
    logic [7:0]  datl_sh_q, datl_sh_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        chk_err_q, chk_err_d;
    logic        to_err_q, to_err_d;
    logic        busy_q, busy_d;

    logic        w_timeout;

    // A frame in progress with no byte for TIMEOUT_END cycles is abandoned;
    // a byte arriving in that same cycle takes priority (checked first below).
    assign w_timeout = (state_q != IDLE) && (cnt_q == TIMEOUT_END);

    // Registers: state, timeout counter, checksum, shadows and all outputs.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 20'd0;
            acc_q     <= 8'h00;
            addr_sh_q <= 8'h00;
            dath_sh_q <= 8'h00;
            datl_sh_q <= 8'h00;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'h00;
            wr_data_q <= 16'h0000;
            chk_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            addr_sh_q <= addr_sh_d;
            dath_sh_q <= dath_sh_d;
            datl_sh_q <= datl_sh_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            chk_err_q <= chk_err_d;
            to_err_q  <= to_err_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state: byte-driven frame walk, timeout abort and output pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        addr_sh_d = addr_sh_q;
        dath_sh_d = dath_sh_q;
        datl_sh_d = datl_sh_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        chk_err_d = 1'b0;
        to_err_d  = 1'b0;

        if (po_flag) begin
            cnt_d = 20'd0;
            case (state_q)
                IDLE: begin
                    if (data_rx == HEAD0) begin
                        state_d = S_HEAD1;
                    end
                end
                S_HEAD1: begin
                    if (data_rx == HEAD1) begin
                        state_d = S_ADDR;
                    end else if (data_rx == HEAD0) begin
                        state_d = S_HEAD1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                S_ADDR: begin
                    addr_sh_d = data_rx;
                    acc_d     = data_rx;
                    state_d   = S_DATH;
                end
                S_DATH: begin
                    dath_sh_d = data_rx;
                    acc_d     = acc_q + data_rx;
                    state_d   = S_DATL;
                end
                S_DATL: begin
                    datl_sh_d = data_rx;
                    acc_d     = acc_q + data_rx;
                    state_d   = S_CHK;
                end
                S_CHK: begin
                    if (data_rx == acc_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_sh_q;
                        wr_data_d = {dath_sh_q, datl_sh_q};
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (state_q == IDLE) begin
            cnt_d = 20'd0;
        end else if (w_timeout) begin
            // Drop the partial frame entirely.
            state_d   = IDLE;
            cnt_d     = 20'd0;
            acc_d     = 8'h00;
            addr_sh_d = 8'h00;
            dath_sh_d = 8'h00;
            datl_sh_d = 8'h00;
            to_err_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end

        busy_d = (state_d != IDLE);
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign chk_err = chk_err_q;
    assign to_err  = to_err_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire
